// File: rtl/fifo_sync_buffer.sv
// Single-clock FIFO with registered full/empty flags and word count.
// Define FIFO_SYNC_BUFFER_FWFT_EN for a first-word-fall-through read port.
module fifo_sync_buffer #(
  parameter int BYTE_WIDTH = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            wr_en,
  input  logic [BYTE_WIDTH*8-1:0]         wr_data,
  output logic                            wr_ack,
  output logic                            wr_full,
  input  logic                            rd_en,
  output logic [BYTE_WIDTH*8-1:0]         rd_data,
  output logic                            rd_valid,
  output logic                            rd_empty,
  output logic [$clog2(FIFO_DEPTH):0]     data_count
);

  localparam int DATA_W = BYTE_WIDTH * 8;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              accept;
  logic              pop;
  logic [CW-1:0]     count_nxt;

  assign accept = wr_en && !wr_full;

`ifdef FIFO_SYNC_BUFFER_FWFT_EN
  // Words still in memory, excluding the one presented in the prefetch register.
  logic [CW-1:0] mem_cnt;
  logic          load;

  assign pop     = rd_en && rd_valid;
  assign mem_cnt = data_count - CW'(rd_valid);
  assign load    = (mem_cnt != '0) && (!rd_valid || pop);
`else
  assign pop = rd_en && !rd_empty;
`endif

  always_comb begin
    count_nxt = data_count;
    if (accept && !pop)
      count_nxt = data_count + CW'(1);
    else if (pop && !accept)
      count_nxt = data_count - CW'(1);
  end

  // Storage array carries no reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (accept)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      data_count <= '0;
      wr_full    <= 1'b0;
      rd_empty   <= 1'b1;
      wr_ack     <= 1'b0;
    end else begin
      wr_ack     <= accept;
      data_count <= count_nxt;
      wr_full    <= (count_nxt == CW'(FIFO_DEPTH));
      rd_empty   <= (count_nxt == '0);
      if (accept)
        wr_ptr <= wr_ptr + AW'(1);
    end
  end

`ifdef FIFO_SYNC_BUFFER_FWFT_EN
  // Prefetch register: refilled whenever it is empty or being acknowledged.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (load) begin
      rd_data  <= mem[rd_ptr];
      rd_ptr   <= rd_ptr + AW'(1);
      rd_valid <= 1'b1;
    end else if (pop) begin
      rd_valid <= 1'b0;
    end
  end
`else
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop;
      if (pop) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + AW'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sync_buffer.sv
// Randomized and directed bench for fifo_sync_buffer against a queue-based model.
module tb_fifo_sync_buffer;

  localparam int BW    = 4;
  localparam int DEPTH = 16;
  localparam int DW    = BW * 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          wr_full;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_empty;
  logic [$clog2(DEPTH):0] data_count;

  fifo_sync_buffer #(.BYTE_WIDTH(BW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .wr_en(wr_en), .wr_data(wr_data), .wr_ack(wr_ack), .wr_full(wr_full),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .rd_empty(rd_empty),
    .data_count(data_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: queue of stored words plus expected registered outputs.
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_data;
  logic          exp_valid;
  logic          exp_ack;
  int            ack_cnt;
  int            vld_cnt;

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_data  = '0;
    exp_valid = 1'b0;
    exp_ack   = 1'b0;
  endtask

  task automatic model_edge(input logic we, input logic [DW-1:0] wd, input logic re);
    int  size;
    logic acc;
    logic pp;
    size = q.size();
    acc  = we && (size < DEPTH);
`ifdef FIFO_SYNC_BUFFER_FWFT_EN
    begin
      int behind;
      pp     = re && exp_valid;
      behind = size - (exp_valid ? 1 : 0);
      if (pp) void'(q.pop_front());
      exp_valid = (exp_valid && !pp) || (behind > 0);
    end
`else
    pp = re && (size > 0);
    exp_valid = pp;
    if (pp) exp_data = q.pop_front();
`endif
    if (acc) q.push_back(wd);
    exp_ack = acc;
    if (acc) ack_cnt++;
    if (pp) vld_cnt++;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".count"}, DW'(data_count), DW'(q.size()));
    check({tag, ".full"},  DW'(wr_full),    DW'(q.size() == DEPTH));
    check({tag, ".empty"}, DW'(rd_empty),   DW'(q.size() == 0));
    check({tag, ".ack"},   DW'(wr_ack),     DW'(exp_ack));
    check({tag, ".valid"}, DW'(rd_valid),   DW'(exp_valid));
`ifdef FIFO_SYNC_BUFFER_FWFT_EN
    if (exp_valid) check({tag, ".data"}, rd_data, q[0]);
`else
    check({tag, ".data"}, rd_data, exp_data);
`endif
  endtask

  // Drive inputs, take one clock edge, update the model, compare after the edge.
  task automatic cycle(input string tag, input logic we, input logic [DW-1:0] wd, input logic re);
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    @(posedge clk);
    model_edge(we, wd, re);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    wr_en = 1'b0;
    rd_en = 1'b0;
    rstn  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
  endtask

  initial begin
    rstn    = 1'b0;
    wr_en   = 1'b1;
    wr_data = 32'hCAFE0000;
    rd_en   = 1'b0;
    model_reset();

    // Reset held with wr_en asserted.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check_outputs("reset");
    end
    @(negedge clk);
    rstn  = 1'b1;
    wr_en = 1'b0;
    #1;

    // Fill, then an overflow write.
    ack_cnt = 0;
    for (int i = 1; i <= DEPTH; i++) cycle("fill", 1'b1, DW'(i), 1'b0);
    cycle("ovf", 1'b1, 32'hDEADBEEF, 1'b0);
    cycle("ovf_idle", 1'b0, '0, 1'b0);
    check("fill.acks", DW'(ack_cnt), DW'(16));
    check("fill.count", DW'(data_count), DW'(16));

    // Drain with two underflow pops.
    vld_cnt = 0;
    for (int i = 0; i < DEPTH + 2; i++) cycle("drain", 1'b0, '0, 1'b1);
    cycle("drain_idle", 1'b0, '0, 1'b0);
`ifndef FIFO_SYNC_BUFFER_FWFT_EN
    check("drain.valids", DW'(vld_cnt), DW'(16));
    check("drain.last", rd_data, 32'h00000010);
`endif
    check("drain.empty", DW'(rd_empty), DW'(1));

    // Simultaneous read/write at count 5, long enough to wrap pointers twice.
    for (int i = 0; i < 5; i++) cycle("pre5", 1'b1, DW'(32'h100 + i), 1'b0);
    for (int i = 0; i < 40; i++) cycle("both", 1'b1, DW'(32'h200 + i), 1'b1);
    check("both.count", DW'(data_count), DW'(5));

    // Simultaneous read/write at full: write is rejected.
    while (q.size() < DEPTH) cycle("tofull", 1'b1, DW'($urandom), 1'b0);
    cycle("fullboth", 1'b1, 32'h0BAD0BAD, 1'b1);
    check("fullboth.count", DW'(data_count), DW'(15));
    check("fullboth.ack", DW'(wr_ack), DW'(0));
    for (int i = 0; i < DEPTH + 2; i++) cycle("drain2", 1'b0, '0, 1'b1);

    // Mid-operation asynchronous reset.
    for (int i = 0; i < 7; i++) cycle("mid_w", 1'b1, DW'(32'h300 + i), 1'b0);
    for (int i = 0; i < 3; i++) cycle("mid_r", 1'b0, '0, 1'b1);
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    check_outputs("async_rst");
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    cycle("a5_w", 1'b1, 32'hA5A5A5A5, 1'b0);
    cycle("a5_idle", 1'b0, '0, 1'b0);
    cycle("a5_r", 1'b0, '0, 1'b1);
    check("a5.data", rd_data, 32'hA5A5A5A5);
    check("a5.valid", DW'(rd_valid), DW'(1));
    for (int i = 0; i < 3; i++) cycle("a5_flush", 1'b0, '0, 1'b1);

`ifdef FIFO_SYNC_BUFFER_FWFT_EN
    // First word falls through one cycle after the write is accepted.
    do_reset();
    cycle("fwft_w", 1'b1, 32'h11111111, 1'b0);
    check("fwft.k_valid", DW'(rd_valid), DW'(0));
    cycle("fwft_k1", 1'b0, '0, 1'b0);
    check("fwft.k1_valid", DW'(rd_valid), DW'(1));
    check("fwft.k1_data", rd_data, 32'h11111111);
    cycle("fwft_ack", 1'b0, '0, 1'b1);
    check("fwft.ack_valid", DW'(rd_valid), DW'(0));
    check("fwft.ack_count", DW'(data_count), DW'(0));
`endif

    // Randomized traffic with varying write/read bias.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int wp;
      int rp;
      wp = (i < 200) ? 75 : (i < 400) ? 30 : 55;
      rp = (i < 200) ? 30 : (i < 400) ? 75 : 55;
      cycle("rand", ($urandom_range(99) < wp), DW'($urandom), ($urandom_range(99) < rp));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
